// File: rtl/riscv_mc_ctrl_if.sv
// riscv_mc_ctrl_if: signal bundle between the multi-cycle control sequencer and its datapath/memory
interface riscv_mc_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [2:0] ImmSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ResultSrc;
    logic [3:0] state_o;
    logic       illegal_inst;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
        output ImmSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, state_o, illegal_inst
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
        input  ImmSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, state_o, illegal_inst
    );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle RISC-V control FSM; MC_CTRL_ILLEGAL_TRAP_EN traps unknown opcodes
module riscv_mc_ctrl (
    input logic            clk,
    input logic            rst_n,
    riscv_mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        TRAP     = 4'd12
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       taken;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic       illegal_q;
    logic       illegal_d;
`endif

    assign taken = (bus.funct3 == 3'b000 && bus.zero) || (bus.funct3 == 3'b001 && !bus.zero);

    // immediate format is a pure function of the opcode, independent of state
    always_comb begin
        case (bus.opcode)
            7'b0000011, 7'b0010011: imm_src = 3'b000;
            7'b0100011:             imm_src = 3'b001;
            7'b0110111:             imm_src = 3'b010;
            7'b1100011:             imm_src = 3'b101;
            7'b1101111:             imm_src = 3'b110;
            default:                imm_src = 3'b111;
        endcase
    end

    // next state and per-state selects; only the write enables look at mem_ready/zero
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        illegal_d  = illegal_q;
`endif
        case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
                state_d    = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.opcode)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXECR;
                    7'b0010011:             state_d = EXECI;
                    7'b1100011:             state_d = BRANCH;
                    7'b1101111:             state_d = JAL;
                    7'b0110111:             state_d = LUI;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default: begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end
`else
                    default:                state_d = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (bus.opcode == 7'b0000011) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                state_d = bus.mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = bus.mem_ready;
                state_d   = bus.mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = taken;
                state_d   = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = ALUWB;
            end
            LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = ALUWB;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // state register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    // sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end
    assign bus.illegal_inst = illegal_q;
`else
    assign bus.illegal_inst = 1'b0;
`endif

    // outputs are held at zero while reset is asserted so an aborted access drops immediately
    assign bus.mem_req   = rst_n & mem_req;
    assign bus.AdrSrc    = rst_n & adr_src;
    assign bus.IRWrite   = rst_n & ir_write;
    assign bus.PCWrite   = rst_n & pc_write;
    assign bus.RegWrite  = rst_n & reg_write;
    assign bus.MemWrite  = rst_n & mem_write;
    assign bus.ImmSrc    = {3{rst_n}} & imm_src;
    assign bus.ALUSrcA   = {2{rst_n}} & alu_src_a;
    assign bus.ALUSrcB   = {2{rst_n}} & alu_src_b;
    assign bus.ALUOp     = {2{rst_n}} & alu_op;
    assign bus.ResultSrc = {2{rst_n}} & result_src;
    assign bus.state_o   = state_q;
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: directed instruction sequences checked against a path/output model of the sequencer
module tb_riscv_mc_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_mc_ctrl_if bus ();
    riscv_mc_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic       req;
        logic       adr;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic [2:0] imm;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic [1:0] res;
        logic [3:0] st;
        logic       ill;
    } out_t;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
    } step_t;

    int         errors = 0;
    int         checks = 0;
    logic       chk_en = 1'b0;
    logic [3:0] exp_st = 4'd0;
    logic       exp_ill = 1'b0;
    int         rw_cnt, mw_cnt, pcw_cnt, irw_cnt, req_cnt, adr_cnt;
    logic [3:0] seen[$];
    step_t      path[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011: return 3'b000;
            7'b0100011:             return 3'b001;
            7'b0110111:             return 3'b010;
            7'b1100011:             return 3'b101;
            7'b1101111:             return 3'b110;
            default:                return 3'b111;
        endcase
    endfunction

    // what each state must drive, straight from the per-state output table
    function automatic out_t model(input logic [3:0] st, input logic [6:0] op, input logic [2:0] f3,
                                   input logic z, input logic rdy, input logic ill, input logic rst);
        out_t o;
        o = '0;
        if (!rst) return o;
        o.imm = imm_of(op);
        o.st  = st;
        o.ill = ill;
        case (st)
            4'd0:  begin o.req = 1; o.b = 2'b10; o.res = 2'b10; o.irw = rdy; o.pcw = rdy; end
            4'd1:  begin o.a = 2'b01; o.b = 2'b01; end
            4'd2:  begin o.a = 2'b10; o.b = 2'b01; end
            4'd3:  begin o.req = 1; o.adr = 1; end
            4'd4:  begin o.res = 2'b01; o.rw = 1; end
            4'd5:  begin o.req = 1; o.adr = 1; o.mw = rdy; end
            4'd6:  begin o.a = 2'b10; o.op = 2'b10; end
            4'd7:  begin o.a = 2'b10; o.b = 2'b01; o.op = 2'b10; end
            4'd8:  begin o.rw = 1; end
            4'd9:  begin o.a = 2'b10; o.op = 2'b01; o.pcw = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z); end
            4'd10: begin o.a = 2'b01; o.b = 2'b10; o.pcw = 1; end
            4'd11: begin o.a = 2'b11; o.b = 2'b01; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic out_t actual();
        return {bus.mem_req, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite,
                bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ResultSrc, bus.state_o, bus.illegal_inst};
    endfunction

    // the single per-cycle comparison against the model, plus event tallies for literal checks
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle", {10'd0, actual()},
                {10'd0, model(exp_st, bus.opcode, bus.funct3, bus.zero, bus.mem_ready, exp_ill, rst_n)});
            seen.push_back(bus.state_o);
            rw_cnt  += int'(bus.RegWrite);
            mw_cnt  += int'(bus.MemWrite);
            pcw_cnt += int'(bus.PCWrite);
            irw_cnt += int'(bus.IRWrite);
            req_cnt += int'(bus.mem_req);
            adr_cnt += int'(bus.AdrSrc);
        end
    end

    // access states take waits cycles of not-ready before the ready cycle
    task automatic add_acc(input logic [3:0] st, input int waits);
        for (int i = 0; i <= waits; i++) path.push_back('{st, i == waits});
    endtask

    // non-access states ignore mem_ready, so toggle it to prove that
    task automatic add(input logic [3:0] st);
        path.push_back('{st, 1'(path.size() % 2)});
    endtask

    task automatic build(input logic [6:0] op, input int fw, input int aw);
        path.delete();
        add_acc(4'd0, fw);
        add(4'd1);
        case (op)
            7'b0000011: begin add(4'd2); add_acc(4'd3, aw); add(4'd4); end
            7'b0100011: begin add(4'd2); add_acc(4'd5, aw); end
            7'b0110011: begin add(4'd6); add(4'd8); end
            7'b0010011: begin add(4'd7); add(4'd8); end
            7'b1100011: add(4'd9);
            7'b1101111: begin add(4'd10); add(4'd8); end
            7'b0110111: begin add(4'd11); add(4'd8); end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            default: repeat (3) add(4'd12);
`else
            default: ;
`endif
        endcase
    endtask

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input int fw, input int aw, input int stop);
        build(op, fw, aw);
        bus.opcode = op;
        bus.funct3 = f3;
        bus.zero   = z;
        seen.delete();
        rw_cnt = 0; mw_cnt = 0; pcw_cnt = 0; irw_cnt = 0; req_cnt = 0; adr_cnt = 0;
        foreach (path[i]) begin
            if (stop >= 0 && i >= stop) break;
            bus.mem_ready = path[i].rdy;
            exp_st        = path[i].st;
            exp_ill       = (path[i].st == 4'd12);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] packed_seen();
        logic [31:0] r;
        r = '0;
        foreach (seen[i]) r = {r[27:0], seen[i]};
        return r;
    endfunction

    initial begin
        bus.opcode    = 7'b0010011;
        bus.funct3    = 3'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        chk_en        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {10'd0, actual()}, 32'd0);
        rst_n = 1'b1;

        run(7'b0010011, 3'd0, 1'b1, 0, 0, -1);
        chk("addi_states", packed_seen(), 32'h0178);
        chk("addi_regwrite", rw_cnt, 1);
        chk("addi_immsrc_cycles", seen.size(), 4);

        run(7'b0010011, 3'd0, 1'b0, 2, 0, -1);
        chk("addi_fetchwait_states", packed_seen(), 32'h000178);
        chk("addi_fetchwait_irwrite", irw_cnt, 1);

        run(7'b0000011, 3'd2, 1'b0, 0, 2, -1);
        chk("lw_states", packed_seen(), 32'h0123334);
        chk("lw_adrsrc", adr_cnt, 3);
        chk("lw_memreq", req_cnt, 4);
        chk("lw_regwrite", rw_cnt, 1);

        run(7'b0100011, 3'd2, 1'b1, 0, 0, -1);
        chk("sw_states", packed_seen(), 32'h0125);
        chk("sw_memwrite", mw_cnt, 1);
        chk("sw_regwrite", rw_cnt, 0);

        run(7'b0110011, 3'd0, 1'b0, 0, 1, -1);
        chk("r_states", packed_seen(), 32'h0168);

        run(7'b1100011, 3'd0, 1'b1, 0, 0, -1);
        chk("beq_taken_pcwrite", pcw_cnt, 2);
        chk("beq_taken_states", packed_seen(), 32'h019);
        run(7'b1100011, 3'd0, 1'b0, 0, 0, -1);
        chk("beq_nottaken_pcwrite", pcw_cnt, 1);
        run(7'b1100011, 3'd1, 1'b0, 0, 0, -1);
        chk("bne_taken_pcwrite", pcw_cnt, 2);
        run(7'b1100011, 3'd1, 1'b1, 0, 0, -1);
        chk("bne_nottaken_pcwrite", pcw_cnt, 1);
        run(7'b1100011, 3'd4, 1'b1, 0, 0, -1);
        chk("blt_unsupported_pcwrite", pcw_cnt, 1);

        run(7'b1101111, 3'd0, 1'b0, 0, 0, -1);
        chk("jal_states", packed_seen(), 32'h01a8);
        chk("jal_pcwrite", pcw_cnt, 2);
        run(7'b0110111, 3'd0, 1'b0, 0, 0, -1);
        chk("lui_states", packed_seen(), 32'h01b8);

        run(7'b1111111, 3'd0, 1'b0, 0, 0, -1);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        chk("illegal_states", packed_seen(), 32'h01ccc);
        chk("illegal_flag", bus.illegal_inst, 1);
        chk("trap_no_req", req_cnt, 1);
        chk_en  = 1'b0;
        rst_n   = 1'b0;
        exp_st  = 4'd0;
        exp_ill = 1'b0;
        #1;
        chk("trap_reset_flag", bus.illegal_inst, 0);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`else
        chk("illegal_states", packed_seen(), 32'h01);
        chk("illegal_flag", bus.illegal_inst, 0);
        chk("illegal_back_to_fetch", bus.state_o, 0);
`endif

        run(7'b0000011, 3'd2, 1'b0, 0, 3, 4);
        chk_en        = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        chk("midread_req", bus.mem_req, 1);
        chk("midread_state", bus.state_o, 3);
        rst_n = 1'b0;
        #1;
        chk("abort_req", bus.mem_req, 0);
        chk("abort_state", bus.state_o, 0);
        chk("abort_outputs", {10'd0, actual()}, 32'd0);
        exp_st  = 4'd0;
        exp_ill = 1'b0;
        chk_en  = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(7'b0010011, 3'd0, 1'b0, 0, 0, -1);
        chk("post_reset_addi_states", packed_seen(), 32'h0178);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Multi-cycle control sequencer for the RISC-V datapath in which the ImmGen, ALU, register file and a shared instruction/data memory port are reused across cycles. It walks each instruction through a Moore state machine and drives the following selects:
- ImmSrc, into the immediate generator.
- the ALU operand selects and ALUOp.
- the result mux select.
- the memory address select.
- the register-file, PC, IR and memory write enables.
- a request/ready handshake to a variable-latency memory port.

It replaces the single-cycle combinational control path.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  7  Instr[6:0] from the latched IR
- funct3  in  3  Instr[14:12]
- zero  in  1  ALU zero flag, combinational in the current cycle
- mem_ready  in  1  memory port completes the access this cycle
- mem_req  out  1  memory access request
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load IR and OldPC
- PCWrite  out  1  load PC from the result bus
- RegWrite  out  1  register-file write
- MemWrite  out  1  data write strobe
- ImmSrc  out  3  000 I, 001 S, 010 U, 101 B, 110 J, 111 none
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4
- ALUOp  out  2  00 add, 01 sub, 10 decode funct3/funct7
- ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALUResult
- state_o  out  4  current state encoding, for debug
- illegal_inst  out  1  sticky illegal-opcode flag

## Operation
State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11, TRAP=12.

Output rules:
- Moore outputs are decoded from the state.
- The only Mealy terms are IRWrite, PCWrite and MemWrite, which use mem_ready and zero.
- Any output not listed for a state is 0 / 00.

ImmSrc:
- Decoded combinationally from opcode in every state.
- 0000011 and 0010011 → 000; 0100011 → 001; 0110111 → 010; 1100011 → 101; 1101111 → 110; anything else → 111.

Per-state outputs and transitions:
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, IRWrite=PCWrite=mem_ready. Go to DECODE on mem_ready; otherwise hold.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, which precomputes the branch target into ALUOut. Next state by opcode:
  - lw/sw → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - any other opcode → illegal (see Configuration)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. Go to MEMWB on mem_ready.
- MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=mem_ready. Go to FETCH on mem_ready.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite=taken, where taken = (funct3=000 & zero) | (funct3=001 & !zero).
  - Other funct3 values are not taken.
  - Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Go to ALUWB, which writes rd=OldPC+4.
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00. Go to ALUWB.
- TRAP: all outputs idle. Hold until reset.

## Timing
Reset:
- rst_n low forces state=FETCH and illegal_inst=0 asynchronously.
- While rst_n is low, every output is forced to 0, including mem_req.
- The first fetch request is in the first clk cycle after deassertion.

Instruction latency in cycles with mem_ready tied 1: R/I-ALU 4, lw 5, sw 4, branch 3, jal 4, lui 4.

Memory handshake:
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Outputs stay stable while waiting.
- mem_ready is ignored in all other states.

Write enables:
- IRWrite, PCWrite and MemWrite are asserted only in the cycle mem_ready=1, so at most one write per access.
- In BRANCH, PCWrite follows zero in the same cycle; there is no registered compare.

Reset during an access:
- Reset mid-access aborts it.
- mem_req drops in the same cycle; no partial write strobe is generated.

## Configuration
Macro MC_CTRL_ILLEGAL_TRAP_EN:
- Defined: an unknown opcode in DECODE goes to TRAP and sets illegal_inst=1 on that edge. The flag stays 1 until reset, and no further requests are issued.
- Undefined: an unknown opcode goes to FETCH (executes as a NOP; PC was already advanced). illegal_inst is tied to 0 and TRAP is unreachable.

## Test plan
- addi, opcode 0010011, mem_ready=1 → states 0,1,7,8,0; ImmSrc=000; RegWrite exactly 1 cycle (ALUWB); 4 cycles total.
- lw with mem_ready low 2 cycles in MEMREAD → states 0,1,2,3,3,3,4; AdrSrc=1 and mem_req=1 held for 3 cycles; RegWrite with ResultSrc=01.
- sw, mem_ready=1 → ImmSrc=001; MemWrite one cycle in MEMWRITE; RegWrite never asserted.
- beq (funct3=000) with zero=1 → PCWrite=1 in BRANCH, ImmSrc=101. Same instruction with zero=0 → PCWrite=0. bne with zero=0 → PCWrite=1.
- jal then lui → jal: states 0,1,10,8, PCWrite in JAL, ImmSrc=110; lui: states 0,1,11,8, ALUSrcA=11, ImmSrc=010.
- opcode 1111111:
  - With MC_CTRL_ILLEGAL_TRAP_EN: state 12 and illegal_inst=1, both sticky.
  - Without the macro: back to FETCH, illegal_inst=0.
  - Assert rst_n=0 mid-MEMREAD: mem_req=0 immediately, state 0.
